// File: rtl/multi_tick_generator.sv
// Multi-channel programmable tick generator: NUM_CH divisor counters emitting one-cycle ticks,
// periodic or one-shot. Optional prescaler cascading is built when MULTI_TICK_CASCADE_EN is defined.
module multi_tick_generator #(
    parameter int INPUT_FREQ = 100_000_000,
    parameter int DEFAULT_HZ = 1000,
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    input  logic              cfg_casc,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(INPUT_FREQ / DEFAULT_HZ);

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] oneshot_q;

    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] wrap;
    logic              cnt_en;

`ifdef MULTI_TICK_CASCADE_EN
    logic [NUM_CH-1:0] casc_q;
    logic              carry;
`else
    logic unused_casc;
    assign unused_casc = cfg_casc;
`endif

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        cfg_hit = '0;
        adv     = '0;
        wrap    = '0;
        cnt_en  = 1'b1;
`ifdef MULTI_TICK_CASCADE_EN
        carry   = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_en = 1'b1;
`ifdef MULTI_TICK_CASCADE_EN
            // Cascaded channels count the wrap of their predecessor so both ticks land in the same cycle.
            if (i > 0 && casc_q[i]) cnt_en = carry;
`endif
            cfg_hit[i] = cfg_we && (32'(cfg_ch) == i);
            adv[i]     = !cfg_hit[i] && !sync_clr && ch_en[i] && (div_q[i] != '0)
                         && !done[i] && cnt_en;
            wrap[i]    = adv[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
`ifdef MULTI_TICK_CASCADE_EN
            carry      = wrap[i];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= RESET_DIV;
                cnt_q[i] <= '0;
            end
            oneshot_q <= '0;
            tick      <= '0;
            done      <= '0;
`ifdef MULTI_TICK_CASCADE_EN
            casc_q    <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tick[i] <= wrap[i];
                if (cfg_hit[i]) begin
                    div_q[i]     <= cfg_div;
                    oneshot_q[i] <= cfg_oneshot;
`ifdef MULTI_TICK_CASCADE_EN
                    casc_q[i]    <= cfg_casc;
`endif
                    cnt_q[i]     <= '0;
                    done[i]      <= 1'b0;
                end else if (sync_clr || !ch_en[i]) begin
                    cnt_q[i] <= '0;
                    done[i]  <= 1'b0;
                end else if (adv[i]) begin
                    if (wrap[i]) begin
                        cnt_q[i] <= '0;
                        if (oneshot_q[i]) done[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DIV_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed self-checking bench for multi_tick_generator; tick/done histories are captured per cycle
// and compared against hand-computed bit patterns (bit k = cycle k+1 after the stimulus edge).
module tb_multi_tick_generator;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 32;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic              cfg_casc;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] done;

    int checks = 0;
    int errors = 0;

    logic [63:0] tick_hist [NUM_CH];
    logic [63:0] done_hist [NUM_CH];

    multi_tick_generator #(
        .INPUT_FREQ(1000),
        .DEFAULT_HZ(100),
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_en      (ch_en),
        .sync_clr   (sync_clr),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .cfg_casc   (cfg_casc),
        .tick       (tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int ncyc);
        for (int c = 0; c < NUM_CH; c++) begin
            tick_hist[c] = '0;
            done_hist[c] = '0;
        end
        for (int k = 0; k < ncyc; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                tick_hist[c][k] = tick[c];
                done_hist[c][k] = done[c];
            end
        end
    endtask

    task automatic cfg_write(input int ch, input int div, input logic oneshot, input logic casc);
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_div     = DIV_W'(div);
        cfg_oneshot = oneshot;
        cfg_casc    = casc;
        step();
        cfg_we      = 1'b0;
    endtask

    task automatic sync_pulse();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ch_en = '0; sync_clr = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0; cfg_casc = 1'b0;
        step();
        step();
        checks++;
        if (tick !== 4'b0000) begin
            errors++; $display("FAIL reset_tick: got %b expected 0000", tick);
        end
        checks++;
        if (done !== 4'b0000) begin
            errors++; $display("FAIL reset_done: got %b expected 0000", done);
        end
    endtask

    task automatic test_reset_default();
        logic [63:0] exp0;
        exp0 = (64'd1 << 9) | (64'd1 << 19) | (64'd1 << 29);
        ch_en = 4'b0001;
        reset = 1'b1;
        capture(30);
        checks++;
        if (tick_hist[0] !== exp0) begin
            errors++; $display("FAIL default_tick0: got %h expected %h", tick_hist[0], exp0);
        end
        checks++;
        if ((tick_hist[1] | tick_hist[2] | tick_hist[3]) !== 64'd0) begin
            errors++; $display("FAIL default_other_ticks: got %h expected 0",
                               tick_hist[1] | tick_hist[2] | tick_hist[3]);
        end
        checks++;
        if (done_hist[0] !== 64'd0) begin
            errors++; $display("FAIL default_done0: got %h expected 0", done_hist[0]);
        end
    endtask

    task automatic test_reprogram();
        logic [63:0] exp1;
        exp1 = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 8);
        ch_en = 4'b0011;
        cfg_write(1, 3, 1'b0, 1'b0);
        capture(9);
        checks++;
        if (tick_hist[1] !== exp1) begin
            errors++; $display("FAIL div3_tick1: got %h expected %h", tick_hist[1], exp1);
        end
        cfg_write(1, 0, 1'b0, 1'b0);
        capture(25);
        checks++;
        if (tick_hist[1] !== 64'd0) begin
            errors++; $display("FAIL div0_tick1: got %h expected 0", tick_hist[1]);
        end
    endtask

    task automatic test_div_one();
        cfg_write(1, 1, 1'b0, 1'b0);
        capture(5);
        checks++;
        if (tick_hist[1] !== 64'h1F) begin
            errors++; $display("FAIL div1_tick1: got %h expected 1f", tick_hist[1]);
        end
    endtask

    task automatic test_cfg_sync_priority();
        // ch1 takes div=2 while sync_clr restarts ch0 (div 10) from zero.
        sync_clr = 1'b1;
        cfg_write(1, 2, 1'b0, 1'b0);
        sync_clr = 1'b0;
        capture(10);
        checks++;
        if (tick_hist[1] !== 64'h2AA) begin
            errors++; $display("FAIL prio_tick1: got %h expected 2aa", tick_hist[1]);
        end
        checks++;
        if (tick_hist[0] !== 64'h200) begin
            errors++; $display("FAIL prio_tick0: got %h expected 200", tick_hist[0]);
        end
    endtask

    task automatic test_oneshot();
        ch_en = 4'b0111;
        cfg_write(2, 5, 1'b1, 1'b0);
        capture(12);
        checks++;
        if (tick_hist[2] !== 64'h010) begin
            errors++; $display("FAIL oneshot_tick2: got %h expected 010", tick_hist[2]);
        end
        checks++;
        if (done_hist[2] !== 64'hFF0) begin
            errors++; $display("FAIL oneshot_done2: got %h expected ff0", done_hist[2]);
        end
        ch_en[2] = 1'b0;
        step();
        checks++;
        if (done[2] !== 1'b0 || tick[2] !== 1'b0) begin
            errors++; $display("FAIL oneshot_disable: got done=%b tick=%b expected 0 0", done[2], tick[2]);
        end
        ch_en[2] = 1'b1;
        capture(10);
        checks++;
        if (tick_hist[2] !== 64'h010 || done_hist[2] !== 64'h3F0) begin
            errors++; $display("FAIL oneshot_rearm: got tick=%h done=%h expected 010 3f0",
                               tick_hist[2], done_hist[2]);
        end
    endtask

    task automatic test_realign();
        ch_en = 4'b1111;
        cfg_write(0, 4, 1'b0, 1'b0);
        step();
        cfg_write(3, 4, 1'b0, 1'b0);
        capture(8);
        checks++;
        if (tick_hist[0] !== 64'h22 || tick_hist[3] !== 64'h88) begin
            errors++; $display("FAIL realign_before: got ch0=%h ch3=%h expected 22 88",
                               tick_hist[0], tick_hist[3]);
        end
        sync_clr = 1'b1;
        step();
        checks++;
        if (tick !== 4'b0000) begin
            errors++; $display("FAIL realign_hold: got %b expected 0000", tick);
        end
        sync_clr = 1'b0;
        capture(8);
        checks++;
        if (tick_hist[0] !== 64'h88 || tick_hist[3] !== 64'h88) begin
            errors++; $display("FAIL realign_after: got ch0=%h ch3=%h expected 88 88",
                               tick_hist[0], tick_hist[3]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] exp;
        exp = (64'd1 << 9) | (64'd1 << 19);
        cfg_write(0, 10, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step();
        checks++;
        if (done[2] !== 1'b1) begin
            errors++; $display("FAIL premid_done2: got %b expected 1", done[2]);
        end
        reset = 1'b0;
        step();
        checks++;
        if (tick !== 4'b0000 || done !== 4'b0000) begin
            errors++; $display("FAIL midreset_out: got tick=%b done=%b expected 0000 0000", tick, done);
        end
        reset = 1'b1;
        ch_en = 4'b1111;
        capture(20);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (tick_hist[c] !== exp || done_hist[c] !== 64'd0) begin
                errors++; $display("FAIL midreset_ch%0d: got tick=%h done=%h expected %h 0",
                                   c, tick_hist[c], done_hist[c], exp);
            end
        end
    endtask

    task automatic test_cascade();
        logic [63:0] exp1;
`ifdef MULTI_TICK_CASCADE_EN
        exp1 = 64'h820;
`else
        exp1 = 64'h924;
`endif
        ch_en = 4'b0011;
        cfg_write(0, 2, 1'b0, 1'b0);
        cfg_write(1, 3, 1'b0, 1'b1);
        sync_pulse();
        capture(12);
        checks++;
        if (tick_hist[0] !== 64'hAAA) begin
            errors++; $display("FAIL cascade_tick0: got %h expected aaa", tick_hist[0]);
        end
        checks++;
        if (tick_hist[1] !== exp1) begin
            errors++; $display("FAIL cascade_tick1: got %h expected %h", tick_hist[1], exp1);
        end
    endtask

    initial begin
        test_reset();
        test_reset_default();
        test_reprogram();
        test_div_one();
        test_cfg_sync_priority();
        test_oneshot();
        test_realign();
        test_reset_mid_run();
        test_cascade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_tick_generator.md
# multi_tick_generator

Multi-channel, runtime-programmable tick source: NUM_CH independent counters, each emitting a one-cycle `tick` pulse every N clocks, N loaded through a simple write port. Each channel runs periodic or one-shot, with per-channel enable and a global phase-realign strobe. It sits between the system clock and timing consumers: I2C bit timers, debouncers, game-step and display-refresh timers.

## Interface
- `INPUT_FREQ`, 100_000_000: clock frequency in Hz.
- `DEFAULT_HZ`, 1000: reset tick rate of every channel; reset divisor = INPUT_FREQ / DEFAULT_HZ.
- `NUM_CH`, 4: channel count, 1..16.
- `DIV_W`, 32: divisor and counter width; reset divisor must fit.
- `CH_W` (localparam): max(1, $clog2(NUM_CH)).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low: sampled 0 at a rising edge resets the block.
- `ch_en`  in  NUM_CH  per-channel run enable.
- `sync_clr`  in  1  realign all channels: clear counters, ticks, done flags.
- `cfg_we`  in  1  divisor/mode write strobe, one cycle.
- `cfg_ch`  in  CH_W  target channel; values ≥ NUM_CH are ignored.
- `cfg_div`  in  DIV_W  new divisor N.
- `cfg_oneshot`  in  1  mode for target channel: 1 = one-shot, 0 = periodic.
- `cfg_casc`  in  1  cascade select for target channel (see Configuration).
- `tick`  out  NUM_CH  registered one-cycle pulse per channel.
- `done`  out  NUM_CH  one-shot channel has fired and is halted.

## Operation
- Per-channel state: `div[DIV_W]`, `cnt[DIV_W]`, `oneshot`, `casc`, `done`, `tick` (all registered).
- Reset (`reset`=0): div = INPUT_FREQ/DEFAULT_HZ, cnt=0, oneshot=0, casc=0, done=0, tick=0 for all channels.
- Advance condition per channel: ch_en[i]=1, div≠0, done=0, and count-enable (every clk; or tick[i-1] when cascaded).
- On advance: if cnt == div−1 → cnt<=0, tick<=1, and done<=1 if oneshot; else cnt<=cnt+1, tick<=0.
- Any cycle without advance: tick<=0, cnt holds.
- ch_en[i]=0: cnt<=0, tick<=0, done<=0 (disable re-arms one-shot).
- div=0: channel halted, never ticks; cnt held at 0.
- div=1: tick high every advancing cycle (continuous while enabled in clk mode).
- Cfg write (cfg_we=1, cfg_ch<NUM_CH): div<=cfg_div, oneshot<=cfg_oneshot, casc<=cfg_casc, cnt<=0, tick<=0, done<=0 for that channel only.
- Priority, highest first: reset, cfg write (target channel), sync_clr, ch_en=0, advance. cfg_we together with sync_clr: target channel takes the new config; all channels clear.
- Counter arithmetic: unsigned, DIV_W bits. The wrap point is compared against div−1 only, and cnt is always cleared on a div change, so cnt never exceeds div−1.

## Timing
- Periodic, clk mode: after enable (or a cfg write / sync_clr), the first tick is high during cycle N (N rising edges later). After that, ticks are exactly N cycles apart, each 1 cycle wide.
- One-shot: a single tick at cycle N, done goes high in the same cycle as the tick and stays high. No further ticks until a cfg write, sync_clr, or ch_en low.
- Cfg write takes effect at the edge that samples cfg_we. Counting with the new div starts from 0 on the next cycle.
- sync_clr held high: all ticks stay low. Counting resumes from 0 on the first cycle after release, so channels with equal div tick in the same cycle.
- No combinational path from inputs to outputs.

## Configuration
- Macro `MULTI_TICK_CASCADE_EN`.
- Defined: a channel i ≥ 1 with casc=1 advances only in cycles where tick[i−1]=1. Its period is div[i]·(period of i−1), giving a prescaler chain. Channel 0 ignores casc.
- Undefined: casc storage and cascade logic are not built. cfg_casc is ignored and every channel counts clk.

## Test plan
- Reset default (INPUT_FREQ=1000, DEFAULT_HZ=100), ch_en=4'b0001, reset released → tick[0] at cycles 10, 20, 30; other ticks 0; done=0.
- Reprogram: write ch1 div=3 periodic, ch_en[1]=1 → tick[1] at cycles 3, 6, 9 after the write. Write div=0 → tick[1] stays 0 indefinitely.
- One-shot: write ch2 div=5 oneshot=1, enabled → single tick[2] at cycle 5, done[2]=1 held. Drop ch_en[2] one cycle and raise it → done clears, tick again 5 cycles later.
- Realign: ch0 div=4, ch3 div=4 started 2 cycles apart. Pulse sync_clr → both tick on the same cycle, 4 cycles after release.
- Reset mid-run: pull reset low while cnt=7 (div=10) → next cycle tick=0, done=0, div back to 10. First tick 10 cycles after release.
- With `MULTI_TICK_CASCADE_EN`: ch0 div=2, ch1 div=3 casc=1 → tick[1] every 6 cycles, coincident with every third tick[0]. Without the macro, the same writes give tick[1] every 3 cycles.
